// File: rtl/td4_pkg.sv
// Shared types for the TD4 sequencer: opcodes, FSM states, adder sources and jump kinds.
// The IDLE state exists only when TD4_SINGLE_STEP_EN is defined.
package td4_pkg;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        SRC_A    = 2'b00,
        SRC_B    = 2'b01,
        SRC_IN   = 2'b10,
        SRC_ZERO = 2'b11
    } src_e;

`ifdef TD4_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_IDLE  = 2'b10
    } state_e;
`else
    typedef enum logic [0:0] {
        ST_FETCH = 1'b0,
        ST_EXEC  = 1'b1
    } state_e;
`endif

    typedef enum logic [1:0] {
        JK_NONE = 2'b00,
        JK_JMP  = 2'b01,
        JK_JNC  = 2'b10
    } jump_e;

    function automatic logic [3:0] pc_inc(input logic [3:0] pc_in);
        return pc_in + 4'd1;
    endfunction

endpackage

// File: rtl/td4_decoder.sv
// Combinational TD4 instruction decode: IR -> adder source, immediate, write strobe,
// jump kind and carry-update enable. Undefined opcodes decode to a NOP.
module td4_decoder
    import td4_pkg::*;
(
    input  logic [7:0] i_ir,
    output src_e       o_src_sel,
    output logic [3:0] o_imm,
    output logic       o_ld_a,
    output logic       o_ld_b,
    output logic       o_ld_out,
    output jump_e      o_jump,
    output logic       o_carry_upd
);

    logic [3:0] w_op;
    logic       w_mask_imm;

    assign w_op = i_ir[7:4];

    // Opcode decode; register moves and IN force the adder immediate to zero.
    always_comb begin
        o_src_sel   = SRC_ZERO;
        o_ld_a      = 1'b0;
        o_ld_b      = 1'b0;
        o_ld_out    = 1'b0;
        o_jump      = JK_NONE;
        o_carry_upd = 1'b0;
        w_mask_imm  = 1'b0;
        case (w_op)
            OP_ADD_A: begin
                o_src_sel   = SRC_A;
                o_ld_a      = 1'b1;
                o_carry_upd = 1'b1;
            end
            OP_MOV_AB: begin
                o_src_sel  = SRC_B;
                o_ld_a     = 1'b1;
                w_mask_imm = 1'b1;
            end
            OP_IN_A: begin
                o_src_sel  = SRC_IN;
                o_ld_a     = 1'b1;
                w_mask_imm = 1'b1;
            end
            OP_MOV_AI: begin
                o_src_sel = SRC_ZERO;
                o_ld_a    = 1'b1;
            end
            OP_MOV_BA: begin
                o_src_sel  = SRC_A;
                o_ld_b     = 1'b1;
                w_mask_imm = 1'b1;
            end
            OP_ADD_B: begin
                o_src_sel   = SRC_B;
                o_ld_b      = 1'b1;
                o_carry_upd = 1'b1;
            end
            OP_IN_B: begin
                o_src_sel  = SRC_IN;
                o_ld_b     = 1'b1;
                w_mask_imm = 1'b1;
            end
            OP_MOV_BI: begin
                o_src_sel = SRC_ZERO;
                o_ld_b    = 1'b1;
            end
            OP_OUT_B: begin
                o_src_sel = SRC_B;
                o_ld_out  = 1'b1;
            end
            OP_OUT_I: begin
                o_src_sel = SRC_ZERO;
                o_ld_out  = 1'b1;
            end
            OP_JNC: begin
                o_jump = JK_JNC;
            end
            OP_JMP: begin
                o_jump = JK_JMP;
            end
            default: begin
                o_src_sel = SRC_ZERO;
            end
        endcase
        if (w_mask_imm) begin
            o_imm = 4'h0;
        end else begin
            o_imm = i_ir[3:0];
        end
    end

endmodule

// File: rtl/td4_sequencer.sv
// TD4 control sequencer: two-tick FETCH/EXEC instruction cycle owning PC, IR and carry.
// Defining TD4_SINGLE_STEP_EN adds run/step inputs and an IDLE state for single stepping.
module td4_sequencer
    import td4_pkg::*;
#(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
`ifdef TD4_SINGLE_STEP_EN
    input  logic       run,
    input  logic       step,
`endif
    output logic [3:0] rom_addr,
    input  logic [7:0] rom_data,
    input  logic       alu_cout,
    output logic [1:0] src_sel,
    output logic [3:0] imm,
    output logic       ld_a,
    output logic       ld_b,
    output logic       ld_out,
    output logic       carry,
    output logic [3:0] pc
);

    state_e     r_state;
    state_e     w_state_nxt;
    logic [3:0] r_pc;
    logic [3:0] w_pc_nxt;
    logic [7:0] r_ir;
    logic [7:0] w_ir_nxt;
    logic       r_carry;
    logic       w_carry_nxt;
    logic       w_exec;

    src_e       w_dec_src;
    logic [3:0] w_dec_imm;
    logic       w_dec_ld_a;
    logic       w_dec_ld_b;
    logic       w_dec_ld_out;
    jump_e      w_dec_jump;
    logic       w_dec_carry_upd;

`ifdef TD4_SINGLE_STEP_EN
    logic       r_step_q;
    logic       r_step_pend;
    logic       w_step_pend_nxt;
    logic       w_step_rise;
    logic       w_leave_idle;

    assign w_step_rise = step & ~r_step_q;
`endif

    td4_decoder u_decoder (
        .i_ir        (r_ir),
        .o_src_sel   (w_dec_src),
        .o_imm       (w_dec_imm),
        .o_ld_a      (w_dec_ld_a),
        .o_ld_b      (w_dec_ld_b),
        .o_ld_out    (w_dec_ld_out),
        .o_jump      (w_dec_jump),
        .o_carry_upd (w_dec_carry_upd)
    );

    // Next-state, PC, IR and carry computation; nothing moves while tick is low.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_nxt    = r_ir;
        w_carry_nxt = r_carry;
        w_exec      = 1'b0;
`ifdef TD4_SINGLE_STEP_EN
        w_leave_idle = 1'b0;
`endif
        case (r_state)
            ST_FETCH: begin
                if (tick) begin
                    w_ir_nxt    = rom_data;
                    w_state_nxt = ST_EXEC;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (tick) begin
                    w_exec = 1'b1;
                    if (w_dec_carry_upd) begin
                        w_carry_nxt = alu_cout;
                    end else begin
                        w_carry_nxt = 1'b0;
                    end
                    // JNC tests the carry left by the previous instruction.
                    case (w_dec_jump)
                        JK_JMP: begin
                            w_pc_nxt = r_ir[3:0];
                        end
                        JK_JNC: begin
                            if (!r_carry) begin
                                w_pc_nxt = r_ir[3:0];
                            end else begin
                                w_pc_nxt = pc_inc(r_pc);
                            end
                        end
                        default: begin
                            w_pc_nxt = pc_inc(r_pc);
                        end
                    endcase
`ifdef TD4_SINGLE_STEP_EN
                    if (run) begin
                        w_state_nxt = ST_FETCH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
`else
                    w_state_nxt = ST_FETCH;
`endif
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
`ifdef TD4_SINGLE_STEP_EN
            ST_IDLE: begin
                if (tick && (run || r_step_pend || w_step_rise)) begin
                    w_leave_idle = 1'b1;
                    w_state_nxt  = ST_FETCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_ir    <= 8'h00;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ir    <= w_ir_nxt;
            r_carry <= w_carry_nxt;
        end
    end

`ifdef TD4_SINGLE_STEP_EN
    // A step edge seen in IDLE while tick is low is held until the next tick.
    always_comb begin
        w_step_pend_nxt = 1'b0;
        if (r_state == ST_IDLE) begin
            if (w_leave_idle) begin
                w_step_pend_nxt = 1'b0;
            end else if (w_step_rise) begin
                w_step_pend_nxt = 1'b1;
            end else begin
                w_step_pend_nxt = r_step_pend;
            end
        end else begin
            w_step_pend_nxt = 1'b0;
        end
    end

    // Step edge detector and pending flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step_q    <= 1'b0;
            r_step_pend <= 1'b0;
        end else begin
            r_step_q    <= step;
            r_step_pend <= w_step_pend_nxt;
        end
    end
`endif

    // Strobes are qualified by the live EXEC+tick condition so reset kills them at once.
    assign ld_a     = w_exec & w_dec_ld_a;
    assign ld_b     = w_exec & w_dec_ld_b;
    assign ld_out   = w_exec & w_dec_ld_out;
    assign src_sel  = w_dec_src;
    assign imm      = w_dec_imm;
    assign carry    = r_carry;
    assign pc       = r_pc;
    assign rom_addr = r_pc;

endmodule

// File: tb/tb_td4_sequencer.sv
// Directed self-checking bench for td4_sequencer with a bench-owned 16-word ROM.
module tb_td4_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       alu_cout;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [1:0] src_sel;
    logic [3:0] imm;
    logic       ld_a;
    logic       ld_b;
    logic       ld_out;
    logic       carry;
    logic [3:0] pc;
`ifdef TD4_SINGLE_STEP_EN
    logic       run;
    logic       step;
`endif

    logic [7:0] rom [16];
    int checks = 0;
    int failures = 0;

    logic [7:0] t_instr [16];
    logic [2:0] t_stb   [16];
    logic [1:0] t_src   [16];
    logic [3:0] t_imm   [16];
    logic       t_cout  [16];
    logic       t_cy    [16];
    logic [3:0] t_pc    [16];
    logic       t_dp    [16];

    assign rom_data = rom[rom_addr];

    td4_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
`ifdef TD4_SINGLE_STEP_EN
        .run      (run),
        .step     (step),
`endif
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .alu_cout (alu_cout),
        .src_sel  (src_sel),
        .imm      (imm),
        .ld_a     (ld_a),
        .ld_b     (ld_b),
        .ld_out   (ld_out),
        .carry    (carry),
        .pc       (pc)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        tick = 1'b0;
        alu_cout = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_row(input int i, input logic [7:0] ins, input logic [2:0] stb,
                           input logic [1:0] src, input logic [3:0] im, input logic co,
                           input logic cy, input logic [3:0] npc, input logic dp);
        t_instr[i] = ins; t_stb[i] = stb; t_src[i] = src; t_imm[i] = im;
        t_cout[i] = co; t_cy[i] = cy; t_pc[i] = npc; t_dp[i] = dp;
    endtask

    task automatic test_reset();
        clear_rom();
        rom[0] = 8'h3D;
        rst = 1'b1;
        tick = 1'b1;
        alu_cout = 1'b1;
        #3;
        checks++; if (pc !== 4'h0) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 4'h0); end
        checks++; if (rom_addr !== 4'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=%h", rom_addr, 4'h0); end
        checks++; if (carry !== 1'b0) begin failures++; $display("FAIL reset_carry got=%b exp=0", carry); end
        checks++; if ({ld_a, ld_b, ld_out} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {ld_a, ld_b, ld_out}); end
        checks++; if (src_sel !== 2'b00 || imm !== 4'h0) begin failures++; $display("FAIL reset_ir got src=%b imm=%h exp src=00 imm=0", src_sel, imm); end
        cyc();
        checks++; if (pc !== 4'h0 || src_sel !== 2'b00) begin failures++; $display("FAIL reset_hold got pc=%h src=%b exp pc=0 src=00", pc, src_sel); end
    endtask

    task automatic test_mov_imm();
        rst = 1'b0;
        alu_cout = 1'b0;
        #1;
        checks++; if (ld_a !== 1'b0) begin failures++; $display("FAIL movi_fetch_ld_a got=%b exp=0", ld_a); end
        cyc();
        checks++; if (ld_a !== 1'b1 || ld_b !== 1'b0 || ld_out !== 1'b0) begin failures++; $display("FAIL movi_exec_strobes got=%b exp=100", {ld_a, ld_b, ld_out}); end
        checks++; if (src_sel !== 2'b11 || imm !== 4'hD) begin failures++; $display("FAIL movi_exec_dp got src=%b imm=%h exp src=11 imm=d", src_sel, imm); end
        cyc();
        checks++; if (pc !== 4'h1 || carry !== 1'b0 || ld_a !== 1'b0) begin failures++; $display("FAIL movi_after got pc=%h cy=%b ld_a=%b exp pc=1 cy=0 ld_a=0", pc, carry, ld_a); end
    endtask

    task automatic test_carry_jnc();
        clear_rom();
        rom[0] = 8'h01;
        rom[1] = 8'hE3;
        apply_reset();
        tick = 1'b1;
        alu_cout = 1'b1;
        cyc();
        checks++; if (ld_a !== 1'b1 || src_sel !== 2'b00 || imm !== 4'h1) begin failures++; $display("FAIL add_exec got ld_a=%b src=%b imm=%h exp 1 00 1", ld_a, src_sel, imm); end
        cyc();
        checks++; if (carry !== 1'b1 || pc !== 4'h1) begin failures++; $display("FAIL add_carry got cy=%b pc=%h exp cy=1 pc=1", carry, pc); end
        cyc();
        checks++; if ({ld_a, ld_b, ld_out} !== 3'b000) begin failures++; $display("FAIL jnc_strobes got=%b exp=000", {ld_a, ld_b, ld_out}); end
        cyc();
        checks++; if (pc !== 4'h2 || carry !== 1'b0) begin failures++; $display("FAIL jnc_taken_carry got pc=%h cy=%b exp pc=2 cy=0", pc, carry); end
        apply_reset();
        tick = 1'b1;
        alu_cout = 1'b0;
        cyc();
        cyc();
        checks++; if (carry !== 1'b0 || pc !== 4'h1) begin failures++; $display("FAIL add_nocarry got cy=%b pc=%h exp cy=0 pc=1", carry, pc); end
        cyc();
        cyc();
        checks++; if (pc !== 4'h3) begin failures++; $display("FAIL jnc_jump got pc=%h exp pc=3", pc); end
    endtask

    task automatic test_jmp_nop();
        clear_rom();
        rom[0]  = 8'hF9;
        rom[9]  = 8'hF7;
        rom[7]  = 8'hFE;
        rom[14] = 8'h02;
        rom[15] = 8'h85;
        apply_reset();
        tick = 1'b1;
        cyc(); cyc();
        checks++; if (pc !== 4'h9) begin failures++; $display("FAIL jmp9 got pc=%h exp pc=9", pc); end
        cyc(); cyc();
        checks++; if (pc !== 4'h7) begin failures++; $display("FAIL jmp7 got pc=%h exp pc=7", pc); end
        cyc(); cyc();
        checks++; if (pc !== 4'hE) begin failures++; $display("FAIL jmp14 got pc=%h exp pc=e", pc); end
        alu_cout = 1'b1;
        cyc(); cyc();
        checks++; if (pc !== 4'hF || carry !== 1'b1) begin failures++; $display("FAIL add_at14 got pc=%h cy=%b exp pc=f cy=1", pc, carry); end
        cyc();
        checks++; if ({ld_a, ld_b, ld_out} !== 3'b000) begin failures++; $display("FAIL nop_strobes got=%b exp=000", {ld_a, ld_b, ld_out}); end
        cyc();
        checks++; if (pc !== 4'h0 || carry !== 1'b0) begin failures++; $display("FAIL nop_wrap got pc=%h cy=%b exp pc=0 cy=0", pc, carry); end
    endtask

    task automatic test_tick_gating();
        clear_rom();
        rom[0] = 8'h3D;
        apply_reset();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        #1;
        checks++; if (ld_a !== 1'b0) begin failures++; $display("FAIL gate_t0a got ld_a=%b exp=0", ld_a); end
        cyc();
        checks++; if (ld_a !== 1'b0 || pc !== 4'h0) begin failures++; $display("FAIL gate_t0b got ld_a=%b pc=%h exp 0 0", ld_a, pc); end
        cyc();
        checks++; if (ld_a !== 1'b0 || pc !== 4'h0 || imm !== 4'hD) begin failures++; $display("FAIL gate_hold got ld_a=%b pc=%h imm=%h exp 0 0 d", ld_a, pc, imm); end
        tick = 1'b1;
        #1;
        checks++; if (ld_a !== 1'b1) begin failures++; $display("FAIL gate_t1 got ld_a=%b exp=1", ld_a); end
        cyc();
        checks++; if (ld_a !== 1'b0 || pc !== 4'h1) begin failures++; $display("FAIL gate_after got ld_a=%b pc=%h exp 0 1", ld_a, pc); end
    endtask

    task automatic test_reset_mid_exec();
        clear_rom();
        rom[0] = 8'h01;
        rom[1] = 8'h3D;
        apply_reset();
        tick = 1'b1;
        alu_cout = 1'b1;
        cyc(); cyc(); cyc();
        checks++; if (ld_a !== 1'b1 || pc !== 4'h1 || carry !== 1'b1) begin failures++; $display("FAIL pre_rst got ld_a=%b pc=%h cy=%b exp 1 1 1", ld_a, pc, carry); end
        rst = 1'b1;
        #1;
        checks++; if ({ld_a, ld_b, ld_out} !== 3'b000 || pc !== 4'h0 || carry !== 1'b0) begin failures++; $display("FAIL rst_async got stb=%b pc=%h cy=%b exp 000 0 0", {ld_a, ld_b, ld_out}, pc, carry); end
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (ld_a !== 1'b0 || src_sel !== 2'b00) begin failures++; $display("FAIL rst_fetch got ld_a=%b src=%b exp 0 00", ld_a, src_sel); end
        cyc();
        checks++; if (ld_a !== 1'b1 || imm !== 4'h1) begin failures++; $display("FAIL rst_restart got ld_a=%b imm=%h exp 1 1", ld_a, imm); end
    endtask

    task automatic test_back_to_back();
        set_row(0,  8'h90, 3'b001, 2'b01, 4'h0, 1'b0, 1'b0, 4'h1, 1'b1);
        set_row(1,  8'h77, 3'b010, 2'b11, 4'h7, 1'b0, 1'b0, 4'h2, 1'b1);
        set_row(2,  8'h53, 3'b010, 2'b01, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1);
        set_row(3,  8'h6C, 3'b010, 2'b10, 4'h0, 1'b0, 1'b0, 4'h4, 1'b1);
        set_row(4,  8'h1A, 3'b100, 2'b01, 4'h0, 1'b0, 1'b0, 4'h5, 1'b1);
        set_row(5,  8'h2A, 3'b100, 2'b10, 4'h0, 1'b0, 1'b0, 4'h6, 1'b1);
        set_row(6,  8'hB5, 3'b001, 2'b11, 4'h5, 1'b0, 1'b0, 4'h7, 1'b1);
        set_row(7,  8'h4F, 3'b010, 2'b00, 4'h0, 1'b0, 1'b0, 4'h8, 1'b1);
        set_row(8,  8'h03, 3'b100, 2'b00, 4'h3, 1'b1, 1'b1, 4'h9, 1'b1);
        set_row(9,  8'hA3, 3'b000, 2'b00, 4'h0, 1'b1, 1'b0, 4'hA, 1'b0);
        set_row(10, 8'hC1, 3'b000, 2'b00, 4'h0, 1'b1, 1'b0, 4'hB, 1'b0);
        set_row(11, 8'hD2, 3'b000, 2'b00, 4'h0, 1'b0, 1'b0, 4'hC, 1'b0);
        set_row(12, 8'h35, 3'b100, 2'b11, 4'h5, 1'b0, 1'b0, 4'hD, 1'b1);
        set_row(13, 8'h8F, 3'b000, 2'b00, 4'h0, 1'b0, 1'b0, 4'hE, 1'b0);
        set_row(14, 8'h0E, 3'b100, 2'b00, 4'hE, 1'b1, 1'b1, 4'hF, 1'b1);
        set_row(15, 8'hE5, 3'b000, 2'b00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 16; i++) rom[i] = t_instr[i];
        apply_reset();
        tick = 1'b1;
        for (int i = 0; i < 16; i++) begin
            alu_cout = t_cout[i];
            cyc();
            checks++; if ({ld_a, ld_b, ld_out} !== t_stb[i]) begin failures++; $display("FAIL b2b_stb[%0d] got=%b exp=%b", i, {ld_a, ld_b, ld_out}, t_stb[i]); end
            if (t_dp[i]) begin
                checks++; if (src_sel !== t_src[i] || imm !== t_imm[i]) begin failures++; $display("FAIL b2b_dp[%0d] got src=%b imm=%h exp src=%b imm=%h", i, src_sel, imm, t_src[i], t_imm[i]); end
            end
            cyc();
            checks++; if (carry !== t_cy[i] || pc !== t_pc[i]) begin failures++; $display("FAIL b2b_state[%0d] got cy=%b pc=%h exp cy=%b pc=%h", i, carry, pc, t_cy[i], t_pc[i]); end
        end
    endtask

`ifdef TD4_SINGLE_STEP_EN
    task automatic test_single_step();
        int pulses;
        for (int i = 0; i < 16; i++) rom[i] = {4'h3, i[3:0]};
        run = 1'b0;
        step = 1'b0;
        apply_reset();
        tick = 1'b1;
        cyc(); cyc();
        checks++; if (pc !== 4'h1) begin failures++; $display("FAIL ss_first got pc=%h exp=1", pc); end
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (ld_a) pulses++;
        end
        checks++; if (pc !== 4'h1 || pulses != 0) begin failures++; $display("FAIL ss_idle got pc=%h pulses=%0d exp pc=1 pulses=0", pc, pulses); end
        step = 1'b1;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (ld_a) pulses++;
        end
        checks++; if (pc !== 4'h2 || pulses != 1) begin failures++; $display("FAIL ss_step got pc=%h pulses=%0d exp pc=2 pulses=1", pc, pulses); end
        run = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
        checks++; if (pc !== 4'h4) begin failures++; $display("FAIL ss_run got pc=%h exp=4", pc); end
        step = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b1;
        tick = 1'b0;
        alu_cout = 1'b0;
`ifdef TD4_SINGLE_STEP_EN
        run = 1'b1;
        step = 1'b0;
`endif
        @(posedge clk);
        #1;
        test_reset();
        test_mov_imm();
        test_carry_jnc();
        test_jmp_nop();
        test_tick_gating();
        test_reset_mid_exec();
        test_back_to_back();
`ifdef TD4_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
